// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder_verilog cell fed LSB first, carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the o_Overflow (signed overflow) output.

module full_adder_verilog (
    input  logic i_A,
    input  logic i_B,
    input  logic i_Cin,
    output logic o_Sum,
    output logic o_Cout
);
    assign o_Sum  = i_A ^ i_B ^ i_Cin;
    assign o_Cout = (i_A & i_B) | (i_Cin & (i_A ^ i_B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_Overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Partial sum keeps only the upper WIDTH-1 bits; the newest bit arrives via fa_sum.
    logic [WIDTH-2:0] s_sr;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    full_adder_verilog u_fa (
        .i_A    (a_sr[0]),
        .i_B    (b_sr[0]),
        .i_Cin  (c_ff),
        .o_Sum  (fa_sum),
        .o_Cout (fa_cout)
    );

    assign s_next = {fa_sum, s_sr};
    assign o_Busy = (state == S_SHIFT) || (state == S_DONE);
    assign o_Done = (state == S_DONE);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
            o_Sum  <= '0;
            o_Cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            o_Overflow <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        a_sr  <= i_A;
                        b_sr  <= i_B;
                        c_ff  <= i_Cin;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next[WIDTH-1:1];
                    c_ff <= fa_cout;
                    if (cnt == LAST) begin
                        o_Sum  <= s_next;
                        o_Cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        o_Overflow <= c_ff ^ fa_cout;
`endif
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic/timing model plus directed vectors.
// Honours SERIAL_ADDER_OVF_EN when the design is built with it.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Start (start),
        .i_A     (a),
        .i_B     (b),
        .i_Cin   (cin),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_Sum   (sum),
        .o_Cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_Overflow (ovf)
`endif
    );
`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..W shifting, W+1 result cycle.
    int           m_phase = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                int full;
                int sa;
                int sb;
                int ss;
                full   = int'(a) + int'(b) + int'(cin);
                p_sum  = W'(full);
                p_cout = full >= (1 << W);
                sa     = a[W-1] ? int'(a) - (1 << W) : int'(a);
                sb     = b[W-1] ? int'(b) - (1 << W) : int'(b);
                ss     = sa + sb + int'(cin);
                p_ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
                m_phase = 1;
            end
        end else if (m_phase == W) begin
            m_phase = W + 1;
            m_sum   = p_sum;
            m_cout  = p_cout;
            m_ovf   = p_ovf;
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == W + 1));
        check("sum", 32'(sum), 32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then measure cycles to o_Done and check literal results.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] es,
                          input logic ec, input logic eo, input string tag);
        int n;
        a = va;
        b = vb;
        cin = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(W + 1));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: x overflow expectation");
`endif
    endtask

    logic [W-1:0] tt_sum [8];
    int           dones;

    initial begin
        tt_sum = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd3};
        tick();
        tick();
        rst = 1'b0;

        repeat (5) tick();
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_sum", 32'(sum), 32'h00);
        check("t1_cout", 32'(cout), 32'd0);

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "t2");
        tick();
        run_op(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "t3");
        tick();
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "t4");
        tick();

        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        a = 8'hAA;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sum", 32'(sum), 32'h00);
        check("t5_cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        start = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t5_nodone", 32'(dones), 32'd0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "t5b");
        tick();

        // Back-to-back with operands changing every cycle.
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        check("t6_results", 32'(dones >= 4), 32'd1);
        repeat (W + 3) tick();

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            run_op({7'd0, v[2]}, {7'd0, v[1]}, v[0], tt_sum[k], 1'b0, 1'b0,
                   "t6_tt");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
